// File: rtl/mfcc_frame_stacker.sv
// MFCC frame stacker: collects MFCC vectors in a ring of frames and streams
// overlapping windows of NUM_FRAMES frames, one coefficient per beat, with a
// valid/ready handshake. Each completed window retires STRIDE frames.
module mfcc_frame_stacker #(
  parameter int NUM_COEF   = 40,
  parameter int COEF_W     = 16,
  parameter int NUM_FRAMES = 8,
  parameter int STRIDE     = 4,
  parameter int DEPTH      = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_COEF*COEF_W-1:0]        mfcc_feature,
  input  logic                              mfcc_valid,
  input  logic                              flush,
  output logic signed [COEF_W-1:0]          feat_data,
  output logic                              feat_valid,
  input  logic                              feat_ready,
  output logic                              feat_last,
  output logic [$clog2(DEPTH+1)-1:0]        fill_count,
  output logic                              overflow,
  output logic [7:0]                        drop_count
);

  localparam int PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FW     = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam int CW     = (NUM_COEF > 1) ? $clog2(NUM_COEF) : 1;
  localparam int FILL_W = $clog2(DEPTH+1);

  localparam logic [PW:0]     DEPTH_P    = (PW+1)'(DEPTH);
  localparam logic [PW:0]     STRIDE_P   = (PW+1)'(STRIDE);
  localparam logic [FW-1:0]   LAST_FRAME = FW'(NUM_FRAMES-1);
  localparam logic [CW-1:0]   LAST_COEF  = CW'(NUM_COEF-1);
  localparam logic [FILL_W-1:0] FULL_LVL   = FILL_W'(DEPTH);
  localparam logic [FILL_W-1:0] WINDOW_LVL = FILL_W'(NUM_FRAMES);
  localparam logic [FILL_W-1:0] STRIDE_LVL = FILL_W'(STRIDE);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t state, state_d;

  logic [NUM_COEF*COEF_W-1:0] ring [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, rd_slot;
  logic [FW-1:0] frame_cnt;
  logic [CW-1:0] coef_cnt;
  logic [NUM_COEF*COEF_W-1:0] cur_vec;
  logic signed [COEF_W-1:0] cur_coef;
  logic retire, accept, drop, load, last_beat;

  // Modulo-DEPTH pointer advance; n never exceeds DEPTH.
  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [PW:0] n);
    logic [PW:0] s;
    s = {1'b0, p} + n;
    if (s >= DEPTH_P) s = s - DEPTH_P;
    return s[PW-1:0];
  endfunction

  // Saturating 8-bit event counter increment.
  function automatic logic [7:0] sat_inc8(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  assign retire    = feat_valid & feat_ready & feat_last;
  assign accept    = mfcc_valid & ~flush & ((fill_count != FULL_LVL) | retire);
  assign drop      = mfcc_valid & ~flush & ~accept;
  assign rd_slot   = ptr_add(rd_ptr, (PW+1)'(frame_cnt));
  assign cur_vec   = ring[rd_slot];
  assign cur_coef  = cur_vec[int'(coef_cnt)*COEF_W +: COEF_W];
  assign last_beat = (frame_cnt == LAST_FRAME) && (coef_cnt == LAST_COEF);

  // Next-state and beat-load decision.
  always_comb begin
    state_d = state;
    load    = 1'b0;
    case (state)
      IDLE:   if (fill_count >= WINDOW_LVL) state_d = STREAM;
      STREAM: begin
        load = ~feat_valid | (feat_ready & ~feat_last);
        if (retire) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      load    = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Frame storage; contents are not reset.
  always_ff @(posedge clk) begin
    if (accept) ring[wr_ptr] <= mfcc_feature;
  end

  // Ring pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_count <= '0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_count <= '0;
    end else begin
      if (accept) wr_ptr <= ptr_add(wr_ptr, (PW+1)'(1));
      if (retire) rd_ptr <= ptr_add(rd_ptr, STRIDE_P);
      fill_count <= fill_count + FILL_W'(accept) - (retire ? STRIDE_LVL : '0);
    end
  end

  // Output beat register and window position counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      feat_data  <= '0;
      feat_valid <= 1'b0;
      feat_last  <= 1'b0;
      coef_cnt   <= '0;
      frame_cnt  <= '0;
    end else if (flush) begin
      feat_valid <= 1'b0;
      feat_last  <= 1'b0;
      coef_cnt   <= '0;
      frame_cnt  <= '0;
    end else if (load) begin
      feat_data  <= cur_coef;
      feat_last  <= last_beat;
      feat_valid <= 1'b1;
      if (coef_cnt == LAST_COEF) begin
        coef_cnt  <= '0;
        frame_cnt <= last_beat ? '0 : frame_cnt + FW'(1);
      end else begin
        coef_cnt  <= coef_cnt + CW'(1);
      end
    end else if (retire) begin
      feat_valid <= 1'b0;
      feat_last  <= 1'b0;
    end
  end

  // Sticky drop status; survives flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow   <= 1'b1;
      drop_count <= sat_inc8(drop_count);
    end
  end

endmodule

// File: tb/tb_mfcc_frame_stacker.sv
// Testbench for mfcc_frame_stacker: a queue of held frames serves as the
// reference; each window is expected as the first NUM_FRAMES queued frames.
module tb_mfcc_frame_stacker;

  localparam int NC = 40, W = 16, NF = 8, S = 4, D = 16;
  localparam int NB = NF*NC;
  localparam int FILL_W = $clog2(D+1);

  typedef logic [NC*W-1:0] vec_t;

  logic clk = 1'b0;
  logic rst_n;
  vec_t mfcc_feature;
  logic mfcc_valid, flush, feat_ready;
  logic signed [W-1:0] feat_data;
  logic feat_valid, feat_last, overflow;
  logic [FILL_W-1:0] fill_count;
  logic [7:0] drop_count;

  vec_t ref_q[$];
  int   ref_drop;
  logic ref_ovf;
  int   total, bad;

  mfcc_frame_stacker #(.NUM_COEF(NC), .COEF_W(W), .NUM_FRAMES(NF), .STRIDE(S), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .mfcc_feature(mfcc_feature), .mfcc_valid(mfcc_valid),
    .flush(flush), .feat_data(feat_data), .feat_valid(feat_valid), .feat_ready(feat_ready),
    .feat_last(feat_last), .fill_count(fill_count), .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  function automatic vec_t ramp_vec(input int f);
    vec_t v;
    for (int k = 0; k < NC; k++) v[k*W +: W] = W'(f*64 + k);
    return v;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int k = 0; k < NC; k++) v[k*W +: W] = W'($urandom);
    return v;
  endfunction

  task automatic send_vec(input vec_t v);
    @(negedge clk);
    feat_ready   = 1'b0;
    mfcc_feature = v;
    mfcc_valid   = 1'b1;
    @(negedge clk);
    mfcc_valid   = 1'b0;
    if (ref_q.size() < D) ref_q.push_back(v);
    else begin
      ref_ovf  = 1'b1;
      ref_drop = (ref_drop == 255) ? 255 : ref_drop + 1;
    end
  endtask

  task automatic check_status(input string name);
    total++;
    if (fill_count !== FILL_W'(ref_q.size())) begin
      bad++; $display("FAIL %s fill_count got=%0d want=%0d", name, fill_count, ref_q.size());
    end
    total++;
    if (overflow !== ref_ovf || drop_count !== 8'(ref_drop)) begin
      bad++; $display("FAIL %s ovf/drop got=%b/%0d want=%b/%0d", name, overflow, drop_count, ref_ovf, ref_drop);
    end
  endtask

  // Consume up to max_beats beats of the current window, checking each.
  task automatic collect(input int max_beats, input bit rand_ready,
                         output logic [W-1:0] first_d, output logic [W-1:0] last_d);
    int idx, cyc, want;
    bit stalled, r;
    logic [W-1:0] held_d, exp_d;
    logic held_l;
    vec_t fv;
    idx = 0; cyc = 0; stalled = 0; held_d = '0; held_l = 1'b0;
    first_d = 'x; last_d = 'x;
    want = (max_beats < NB) ? max_beats : NB;
    while (idx < want && cyc < 3000 && ref_q.size() >= NF) begin
      @(negedge clk);
      cyc++;
      if (stalled) begin
        total++;
        if (feat_valid !== 1'b1 || feat_data !== held_d || feat_last !== held_l) begin
          bad++; $display("FAIL stall_hold beat=%0d got=%b/%h/%b want=1/%h/%b",
                          idx, feat_valid, feat_data, feat_last, held_d, held_l);
        end
      end
      r = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      feat_ready = r;
      if (feat_valid === 1'b1 && r) begin
        fv = ref_q[idx/NC];
        exp_d = fv[(idx%NC)*W +: W];
        total++;
        if (feat_data !== exp_d) begin
          bad++; $display("FAIL beat_data beat=%0d got=%h want=%h", idx, feat_data, exp_d);
        end
        total++;
        if (feat_last !== (idx == NB-1)) begin
          bad++; $display("FAIL beat_last beat=%0d got=%b want=%b", idx, feat_last, idx == NB-1);
        end
        if (idx == 0) first_d = feat_data;
        last_d = feat_data;
        idx++;
      end
      stalled = (feat_valid === 1'b1) && !r;
      held_d  = feat_data;
      held_l  = feat_last;
    end
    total++;
    if (idx != want) begin
      bad++; $display("FAIL window_beats got=%0d want=%0d", idx, want);
    end
    if (idx == NB) for (int i = 0; i < S; i++) fv = ref_q.pop_front();
  endtask

  task automatic check_zero(input string name);
    total++;
    if (feat_data !== '0 || feat_valid !== 1'b0 || feat_last !== 1'b0 ||
        fill_count !== '0 || overflow !== 1'b0 || drop_count !== 8'd0) begin
      bad++; $display("FAIL %s got data=%h v=%b l=%b fill=%0d ovf=%b drop=%0d want all zero",
                      name, feat_data, feat_valid, feat_last, fill_count, overflow, drop_count);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3 check_zero("reset_async");
    repeat (3) @(posedge clk);
    #1 check_zero("reset_held");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_first_window();
    logic [W-1:0] fd, ld;
    for (int f = 0; f < 8; f++) send_vec(ramp_vec(f));
    check_status("win1_fill8");
    collect(NB, 1'b0, fd, ld);
    total++;
    if (fd !== W'(0) || ld !== W'(7*64+39)) begin
      bad++; $display("FAIL win1_ends got=%0d..%0d want=0..%0d", fd, ld, 7*64+39);
    end
    @(negedge clk);
    check_status("win1_fill4");
    total++;
    if (feat_valid !== 1'b0) begin
      bad++; $display("FAIL win1_idle feat_valid got=%b want=0", feat_valid);
    end
  endtask

  task automatic test_second_window();
    logic [W-1:0] fd, ld;
    for (int f = 8; f < 12; f++) send_vec(ramp_vec(f));
    collect(NB, 1'b0, fd, ld);
    total++;
    if (fd !== W'(256) || ld !== W'(11*64+39)) begin
      bad++; $display("FAIL win2_ends got=%0d..%0d want=256..%0d", fd, ld, 11*64+39);
    end
    @(negedge clk);
    check_status("win2_fill4");
  endtask

  task automatic test_random_stall();
    logic [W-1:0] fd, ld;
    for (int f = 0; f < 4; f++) send_vec(rand_vec());
    collect(NB, 1'b1, fd, ld);
    @(negedge clk);
    check_status("stall_fill4");
  endtask

  task automatic test_overflow();
    logic [W-1:0] fd, ld;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    ref_q.delete();
    check_status("ovf_flushed");
    for (int f = 0; f < 17; f++) send_vec(ramp_vec(f));
    check_status("ovf_full");
    collect(NB, 1'b0, fd, ld);
    total++;
    if (fd !== W'(0) || ld !== W'(7*64+39)) begin
      bad++; $display("FAIL ovf_window got=%0d..%0d want=0..%0d", fd, ld, 7*64+39);
    end
    @(negedge clk);
    check_status("ovf_fill12");
    collect(NB, 1'b1, fd, ld);
    collect(NB, 1'b0, fd, ld);
    @(negedge clk);
    check_status("ovf_fill4");
  endtask

  task automatic test_flush();
    logic [W-1:0] fd, ld;
    for (int f = 0; f < 4; f++) send_vec(rand_vec());
    collect(100, 1'b0, fd, ld);
    @(negedge clk);
    feat_ready   = 1'b0;
    flush        = 1'b1;
    mfcc_feature = rand_vec();
    mfcc_valid   = 1'b1;
    @(negedge clk);
    flush      = 1'b0;
    mfcc_valid = 1'b0;
    ref_q.delete();
    total++;
    if (feat_valid !== 1'b0 || feat_last !== 1'b0) begin
      bad++; $display("FAIL flush_stream got v=%b l=%b want 0/0", feat_valid, feat_last);
    end
    check_status("flush_status");
    repeat (3) @(negedge clk);
    total++;
    if (feat_valid !== 1'b0) begin
      bad++; $display("FAIL flush_idle feat_valid got=%b want=0", feat_valid);
    end
    for (int f = 0; f < 8; f++) send_vec(rand_vec());
    collect(NB, 1'b0, fd, ld);
    @(negedge clk);
    check_status("flush_after");
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] fd, ld;
    for (int f = 0; f < 4; f++) send_vec(rand_vec());
    collect(50, 1'b1, fd, ld);
    #2 rst_n = 1'b0;
    #1 check_zero("reset_mid_async");
    ref_q.delete();
    ref_ovf  = 1'b0;
    ref_drop = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int f = 0; f < 8; f++) send_vec(rand_vec());
    collect(NB, 1'b1, fd, ld);
    @(negedge clk);
    check_status("reset_mid_after");
  endtask

  initial begin
    total = 0; bad = 0;
    ref_drop = 0; ref_ovf = 1'b0;
    mfcc_feature = '0; mfcc_valid = 1'b0; flush = 1'b0; feat_ready = 1'b0;
    test_reset();
    test_first_window();
    test_second_window();
    test_random_stall();
    test_overflow();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
